// File: rtl/instr_sequencer_if.sv
// Instruction-memory fetch bus: one-cycle request with address, later read-data valid.
interface instr_sequencer_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/issue controller: PC, instruction fetch handshake, BEQ/J resolution,
// HALT-word and fetch-timeout stop for the single-cycle CPU.
module instr_sequencer #(
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       TIMEOUT   = 15,
    parameter logic [31:0]       HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    instr_sequencer_if.master   imem,
    output logic [31:0]         cpu_instr,
    output logic                cpu_issue,
    input  logic                cpu_zero,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                halted,
    output logic                err,
    output logic [15:0]         instr_count
);
    localparam int unsigned TMR_W     = 8;
    localparam logic [5:0]  OP_BEQ    = 6'b000100;
    localparam logic [5:0]  OP_J      = 6'b000010;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_t;

    state_t            state;
    logic [31:0]       ir;
    logic [TMR_W-1:0]  timer;

    logic [ADDR_W-1:0] pc4;
    logic [31:0]       pc4_ext;
    logic [31:0]       br_off;
    logic [ADDR_W-1:0] pc_br;
    logic [ADDR_W-1:0] pc_j;
    logic [ADDR_W-1:0] pc_next;

    // Issue decode is combinational so cpu_zero can feed back within EXEC.
    always_comb begin
        cpu_issue = (state == S_EXEC);
        cpu_instr = cpu_issue ? ir : 32'h0000_0000;
    end

    // Next-PC selection; all arithmetic wraps modulo 2^ADDR_W.
    always_comb begin
        pc4     = ADDR_W'(pc + ADDR_W'(4));
        pc4_ext = 32'(pc4);
        br_off  = {{14{ir[15]}}, ir[15:0], 2'b00};
        pc_br   = ADDR_W'(pc4_ext + br_off);
        pc_j    = ADDR_W'({pc4_ext[31:28], ir[25:0], 2'b00});
        pc_next = pc4;
        if (ir[31:26] == OP_BEQ && cpu_zero) begin
            pc_next = pc_br;
        end else if (ir[31:26] == OP_J) begin
            pc_next = pc_j;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= '0;
            ir             <= '0;
            timer          <= '0;
            busy           <= 1'b0;
            halted         <= 1'b0;
            err            <= 1'b0;
            instr_count    <= '0;
        end else begin
            imem.imem_req <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state          <= S_FETCH;
                        pc             <= RESET_PC;
                        err            <= 1'b0;
                        instr_count    <= '0;
                        imem.imem_req  <= 1'b1;
                        imem.imem_addr <= RESET_PC;
                        busy           <= 1'b1;
                        halted         <= 1'b0;
                    end
                end
                S_FETCH: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Data arriving on the last timer cycle still wins over the timeout.
                    if (imem.imem_rvalid) begin
                        ir <= imem.imem_rdata;
                        if (imem.imem_rdata == HALT_WORD) begin
                            state  <= S_HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state <= S_EXEC;
                        end
                    end else if (timer == TMR_LAST) begin
                        err    <= 1'b1;
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_EXEC: begin
                    if (instr_count != 16'hFFFF) begin
                        instr_count <= instr_count + 16'd1;
                    end
                    pc             <= pc_next;
                    imem.imem_req  <= 1'b1;
                    imem.imem_addr <= pc_next;
                    state          <= S_FETCH;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboarded bench: a memory responder checks fetch addresses, an issue
// monitor checks issued words; scenario tasks check status outputs.
module tb_instr_sequencer;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned TIMEOUT = 15;
    localparam logic [31:0] HALT_W  = 32'hFFFF_FFFF;
    localparam logic [31:0] W_ADD   = 32'h012A_4020;
    localparam logic [31:0] W_LW    = 32'h8D09_0004;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              cpu_zero = 1'b0;
    logic [31:0]       cpu_instr;
    logic              cpu_issue;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic              err;
    logic [15:0]       instr_count;

    instr_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    instr_sequencer #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (16'h0000),
        .TIMEOUT  (TIMEOUT),
        .HALT_WORD(HALT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem       (bus),
        .cpu_instr  (cpu_instr),
        .cpu_issue  (cpu_issue),
        .cpu_zero   (cpu_zero),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .err        (err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int req_seen = 0;
    int lat = 1;
    bit mem_en = 1'b1;

    logic [31:0]       mem [logic [15:0]];
    logic [ADDR_W-1:0] exp_addr [$];
    logic [31:0]       exp_instr [$];
    logic              zero_q [$];
    int                issue_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: checks each request address, answers after lat cycles.
    initial begin
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] e;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.imem_req) begin
                a = bus.imem_addr;
                req_seen++;
                total++;
                if (exp_addr.size() == 0) begin
                    bad++;
                    $display("FAIL fetch_addr: unexpected request at addr=%h", a);
                end else begin
                    e = exp_addr.pop_front();
                    if (a !== e) begin
                        bad++;
                        $display("FAIL fetch_addr: got %h expected %h", a, e);
                    end
                end
                if (mem_en) begin
                    repeat (lat) @(posedge clk);
                    #1;
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem.exists(a) ? mem[a] : 32'h0;
                    @(posedge clk);
                    #1;
                    bus.imem_rvalid = 1'b0;
                end
            end
        end
    end

    // Issue monitor: compares issued words with the scoreboard, drives cpu_zero for BEQ.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            total++;
            if (cpu_issue) begin
                issue_cyc.push_back(cyc);
                if (exp_instr.size() == 0) begin
                    bad++;
                    $display("FAIL issue: unexpected issue instr=%h", cpu_instr);
                end else begin
                    e = exp_instr.pop_front();
                    if (cpu_instr !== e) begin
                        bad++;
                        $display("FAIL issue: got %h expected %h", cpu_instr, e);
                    end
                end
                if (cpu_instr[31:26] == 6'b000100)
                    cpu_zero = (zero_q.size() != 0) ? zero_q.pop_front() : 1'b0;
            end else if (cpu_instr !== 32'h0) begin
                bad++;
                $display("FAIL nop_when_idle: cpu_instr=%h expected 00000000", cpu_instr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_halt(input int maxc, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk);
            #1;
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: halted not reached within %0d cycles", name, maxc);
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_addr.size() != 0 || exp_instr.size() != 0) begin
            bad++;
            $display("FAIL %s_drained: addr_left=%0d instr_left=%0d expected 0/0",
                     name, exp_addr.size(), exp_instr.size());
        end
    endtask

    task automatic check_status(input string name, input logic h, input logic e, input logic [15:0] cnt);
        total++;
        if (halted !== h || err !== e || instr_count !== cnt || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_status: halted=%b err=%b count=%0d busy=%b expected %b %b %0d 0",
                     name, halted, err, instr_count, busy, h, e, cnt);
        end
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 16'h0 || cpu_instr !== 32'h0 ||
            cpu_issue !== 1'b0 || pc !== 16'h0 || busy !== 1'b0 || halted !== 1'b0 ||
            err !== 1'b0 || instr_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_outputs: req=%b addr=%h instr=%h issue=%b pc=%h busy=%b halted=%b err=%b cnt=%0d expected all 0",
                     bus.imem_req, bus.imem_addr, cpu_instr, cpu_issue, pc, busy, halted, err, instr_count);
        end
        rst = 1'b0;
        seen = req_seen;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (req_seen != seen || busy !== 1'b0 || pc !== 16'h0) begin
            bad++;
            $display("FAIL idle_no_fetch: reqs=%0d busy=%b pc=%h expected 0 0 0000",
                     req_seen - seen, busy, pc);
        end
    endtask

    task automatic test_straight();
        mem.delete();
        mem[16'h0000] = W_ADD;
        mem[16'h0004] = W_LW;
        mem[16'h0008] = HALT_W;
        lat = 1;
        exp_addr  = '{16'h0000, 16'h0004, 16'h0008};
        exp_instr = '{W_ADD, W_LW};
        issue_cyc.delete();
        do_start();
        wait_halt(100, "straight");
        total++;
        if (issue_cyc.size() != 2) begin
            bad++;
            $display("FAIL straight_issue_count: got %0d expected 2", issue_cyc.size());
        end else if (issue_cyc[1] - issue_cyc[0] != 3) begin
            bad++;
            $display("FAIL straight_spacing: got %0d expected 3", issue_cyc[1] - issue_cyc[0]);
        end
        check_status("straight", 1'b1, 1'b0, 16'd2);
        check_drained("straight");
    endtask

    task automatic test_branch();
        mem.delete();
        mem[16'h0000] = 32'h0800_0004;
        mem[16'h0010] = 32'h1109_FFFF;
        mem[16'h0014] = 32'h0800_0040;
        mem[16'h0100] = HALT_W;
        lat = 1;
        zero_q    = '{1'b1, 1'b0};
        exp_addr  = '{16'h0000, 16'h0010, 16'h0010, 16'h0014, 16'h0100};
        exp_instr = '{32'h0800_0004, 32'h1109_FFFF, 32'h1109_FFFF, 32'h0800_0040};
        do_start();
        wait_halt(200, "branch");
        check_status("branch", 1'b1, 1'b0, 16'd4);
        check_drained("branch");
        total++;
        if (pc !== 16'h0100) begin
            bad++;
            $display("FAIL branch_pc: got %h expected 0100", pc);
        end
    endtask

    task automatic test_wrap();
        mem.delete();
        mem[16'h0000] = 32'h1000_3FFE;
        mem[16'hFFFC] = W_ADD;
        mem[16'h0004] = HALT_W;
        lat = 2;
        zero_q    = '{1'b1, 1'b0};
        exp_addr  = '{16'h0000, 16'hFFFC, 16'h0000, 16'h0004};
        exp_instr = '{32'h1000_3FFE, W_ADD, 32'h1000_3FFE};
        do_start();
        wait_halt(200, "wrap");
        check_status("wrap", 1'b1, 1'b0, 16'd3);
        check_drained("wrap");
    endtask

    task automatic test_timeout_edge();
        mem.delete();
        mem[16'h0000] = W_ADD;
        mem[16'h0004] = HALT_W;
        lat = TIMEOUT;
        exp_addr  = '{16'h0000, 16'h0004};
        exp_instr = '{W_ADD};
        do_start();
        wait_halt(200, "timeout_edge");
        check_status("timeout_edge", 1'b1, 1'b0, 16'd1);
        check_drained("timeout_edge");
    endtask

    task automatic test_timeout();
        int n = 0;
        mem.delete();
        mem_en = 1'b0;
        exp_addr = '{16'h0000};
        do_start();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (halted) break;
        end
        total++;
        if (n != TIMEOUT + 1 || !halted) begin
            bad++;
            $display("FAIL timeout_latency: halted after %0d edges (halted=%b) expected %0d",
                     n, halted, TIMEOUT + 1);
        end
        check_status("timeout", 1'b1, 1'b1, 16'd0);
        mem_en = 1'b1;
        mem[16'h0000] = HALT_W;
        exp_addr = '{16'h0000};
        do_start();
        total++;
        if (err !== 1'b0 || busy !== 1'b1 || halted !== 1'b0 || bus.imem_req !== 1'b1) begin
            bad++;
            $display("FAIL restart_clear: err=%b busy=%b halted=%b req=%b expected 0 1 0 1",
                     err, busy, halted, bus.imem_req);
        end
        wait_halt(100, "restart");
        check_status("restart", 1'b1, 1'b0, 16'd0);
        check_drained("timeout");
    endtask

    task automatic test_reset_mid();
        int seen;
        mem.delete();
        mem[16'h0000] = W_ADD;
        lat = 3;
        exp_addr = '{16'h0000};
        do_start();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || halted !== 1'b0 || pc !== 16'h0 || cpu_issue !== 1'b0 ||
            bus.imem_req !== 1'b0 || instr_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b halted=%b pc=%h issue=%b req=%b cnt=%0d expected 0 0 0000 0 0 0",
                     busy, halted, pc, cpu_issue, bus.imem_req, instr_count);
        end
        rst = 1'b0;
        seen = req_seen;
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (req_seen != seen || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_idle: reqs=%0d busy=%b expected 0 0", req_seen - seen, busy);
        end
        check_drained("reset_mid");
    endtask

    initial begin
        test_reset();
        test_straight();
        test_branch();
        test_wrap();
        test_timeout_edge();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
